profile_snapshot: RTL and testbench
===================================

# profile_snapshot

Downstream companion to the profiling counter: samples its free-running `count` on every stop event and computes the interval length since the previous sample. Each interval is queued in a small FIFO, and software or a trace unit drains it through a valid/ready port. Overflow is tracked with a sticky flag and a saturating drop counter, so no lost measurement goes unreported.

## Interface
- `WIDTH`, 32: width of `count` and of each interval entry.
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `DROPW`, 8: width of the drop counter.

- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `count`  in  WIDTH  counter value from the profiling counter.
- `stop`  in  1  the same stop signal that drives the counter; may be held high for several cycles.
- `clear`  in  1  flush FIFO, clear error state, rebase to current `count`.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts head entry.
- `out_delta`  out  WIDTH  head entry (interval length).
- `level`  out  $clog2(DEPTH)+1  current occupancy.
- `overflow`  out  1  sticky; a capture was dropped.
- `drop_cnt`  out  DROPW  dropped captures, saturating at all-ones.

## Operation
- **Stop edge detection**
  - Register `stop_d` holds `stop` from the previous cycle.
  - A capture event is `cap = stop & ~stop_d`, so a held `stop` yields exactly one capture.
- **Interval computation**
  - On `cap`: `delta = count - last_count`, computed modulo 2^WIDTH, so counter wrap-around gives the correct interval.
  - `last_count <= count` on every `cap`, including a dropped one.
  - The counter does not increment while `stop` is high, so `count` is stable at capture.
- **FIFO**
  - Circular buffer with `DEPTH` entries; read and write pointers are one bit wider than the index.
  - Push condition: `cap` and (not full, or a pop in the same cycle).
  - Pop condition: `out_valid & out_ready`.
  - `out_delta` is the combinational head entry; it shows the last popped value when the FIFO is empty.
- **Drop on full**
  - `cap` while full with no pop discards the entry.
  - `overflow` is set to 1.
  - `drop_cnt` increments, saturating at all-ones.
- **Clear**
  - For one cycle, `clear` resets both pointers, `overflow` and `drop_cnt`, and sets `last_count <= count`.
  - `clear` overrides any simultaneous `cap` or pop; that capture is not queued and not counted as dropped.
- **Reset** (`reset_n` = 0) sets every register to 0:
  - pointers, `last_count`, `stop_d`, `overflow`, `drop_cnt`, and the storage array.
  - Outputs after reset: `out_valid`=0, `level`=0, `overflow`=0, `drop_cnt`=0, `out_delta`=0.
  - Reset asserted mid-operation discards all queued entries at the next edge.

## Timing
- **Capture latency:** a `cap` in cycle N produces the entry at the FIFO tail at edge N+1. With the FIFO empty, `out_valid` rises in cycle N+1.
- **Pop:** takes effect at the edge where `out_valid & out_ready`; the next entry appears the following cycle.
- **Throughput:** one capture per two cycles at most, since edge detection requires `stop` low for at least one cycle between captures. Back-to-back pops, one per cycle, are supported.
- **Simultaneous push and pop**
  - `level` is unchanged.
  - When full, the push is accepted with no drop.
  - When empty, there is no pop (`out_valid`=0); the push alone proceeds.
- **No combinational path** from `out_ready` to `out_valid`. `level` and `overflow` are registered-derived.
- **`out_ready` while `out_valid`=0** is ignored; the pointers do not move.

## Test plan
- **Basic interval:** reset, `count` ramps, `stop` pulses at `count`=100, then at 250 → first entry 100, second 150, `level`=2, `out_valid` in the cycle after each capture.
- **Held stop:** `stop` high for 5 cycles with `count`=40 → exactly one entry, 40; `level`=1.
- **Wrap-around:** with WIDTH=8, `last_count`=250, capture at `count`=4 → entry 10.
- **Overflow:** DEPTH=4, `out_ready`=0, 6 captures → `level`=4, `overflow`=1, `drop_cnt`=2. The first 4 deltas drain in order once `out_ready`=1.
- **Push/pop when full:** FIFO full, `cap` and pop in the same cycle → `level` stays 4, no drop, new entry appears at the tail.
- **Clear and reset:** `clear` together with `cap` at `count`=500 → `level`=0, `overflow`=0, and the next capture at 520 yields 20. Then `reset_n`=0 for one cycle with entries queued → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/profile_snapshot.sv
// -----------------------------------------------------------------------------
// profile_snapshot
//
// Downstream companion to the profiling counter. On every rising edge of
// `stop` it samples the free-running `count`, computes the interval since the
// previous sample (modulo 2^WIDTH, so counter wrap is harmless) and queues it
// in a small circular FIFO. A consumer drains the FIFO through a valid/ready
// port. Captures that arrive while the FIFO is full (and not simultaneously
// being popped) are dropped, which sets a sticky `overflow` flag and bumps a
// saturating drop counter.
//
// Ports
//   clk        : sole clock, all state updates on its rising edge
//   reset_n    : synchronous active-low reset, clears every register
//   count      : counter value from the profiling counter (WIDTH bits)
//   stop       : stop signal shared with the counter; may be held high
//   clear      : flush FIFO, clear error state, rebase to current `count`
//   out_valid  : FIFO non-empty
//   out_ready  : consumer accepts head entry
//   out_delta  : head entry (interval length); last popped value when empty
//   level      : current occupancy, 0..DEPTH
//   overflow   : sticky, a capture was dropped
//   drop_cnt   : number of dropped captures, saturating at all-ones
// -----------------------------------------------------------------------------
module profile_snapshot #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int DROPW = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [WIDTH-1:0]         count,
  input  logic                     stop,
  input  logic                     clear,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_delta,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [DROPW-1:0]         drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   PTR_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] IDX_ONE = AW'(1);

  // Saturating increment for the drop counter.
  function automatic logic [DROPW-1:0] sat_inc(input logic [DROPW-1:0] v);
    return (&v) ? v : v + DROPW'(1);
  endfunction

  // Interval between two counter samples; unsigned subtraction wraps
  // naturally, which gives the right answer across counter roll-over.
  function automatic logic [WIDTH-1:0] interval(input logic [WIDTH-1:0] now,
                                                input logic [WIDTH-1:0] last);
    return now - last;
  endfunction

  logic              stop_d;
  logic [WIDTH-1:0]  last_count;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;

  logic [AW-1:0]     wr_idx;
  logic [AW-1:0]     rd_idx;
  logic              empty;
  logic              full;
  logic              cap;
  logic              pop;
  logic              push;
  logic              drop;
  logic [WIDTH-1:0]  delta;

  assign wr_idx = wr_ptr[AW-1:0];
  assign rd_idx = rd_ptr[AW-1:0];

  // Pointers carry an extra wrap bit so full and empty are distinguishable
  // without a separate occupancy register.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);

  // A held stop produces exactly one capture: only the rising edge counts.
  assign cap   = stop & ~stop_d;
  assign delta = interval(count, last_count);

  // Clear wins over everything; a capture in the clear cycle is neither
  // queued nor counted as dropped. A pop frees a slot in the same cycle, so
  // a capture while full is still accepted when the head is being consumed.
  assign pop   = ~empty & out_ready & ~clear;
  assign push  = cap & (~full | pop) & ~clear;
  assign drop  = cap & full & ~pop & ~clear;

  assign out_valid = ~empty;
  assign level     = wr_ptr - rd_ptr;

  // When empty, the read pointer already sits one past the last popped slot;
  // stepping back one keeps the last consumed interval visible.
  assign out_delta = empty ? mem[rd_idx - IDX_ONE] : mem[rd_idx];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stop_d     <= 1'b0;
      last_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow   <= 1'b0;
      drop_cnt   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      stop_d <= stop;
      if (clear) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        overflow   <= 1'b0;
        drop_cnt   <= '0;
        last_count <= count;
      end else begin
        // The baseline moves on every capture, dropped or not, so the next
        // interval is still measured from the most recent stop.
        if (cap) begin
          last_count <= count;
        end
        if (push) begin
          mem[wr_idx] <= delta;
          wr_ptr      <= wr_ptr + PTR_ONE;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_ONE;
        end
        if (drop) begin
          overflow <= 1'b1;
          drop_cnt <= sat_inc(drop_cnt);
        end
      end
    end
  end

endmodule

// File: tb/tb_profile_snapshot.sv
module tb_profile_snapshot;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int DROPW = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [WIDTH-1:0]  count;
  logic              stop;
  logic              clear;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_delta;
  logic [2:0]        level;
  logic              overflow;
  logic [DROPW-1:0]  drop_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [WIDTH-1:0]  q[$];
  logic [WIDTH-1:0]  m_last;
  logic              m_stop_d;
  logic              m_ovf;
  logic [DROPW-1:0]  m_drop;

  typedef struct {
    logic [WIDTH-1:0] cnt;
    logic             stp;
    logic             clr;
    logic             rdy;
    logic             exp_v;
    logic [2:0]       exp_l;
    logic             chk_d;
    logic [WIDTH-1:0] exp_d;
  } vec_t;

  vec_t tbl [16];

  profile_snapshot #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DROPW(DROPW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .count     (count),
    .stop      (stop),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_delta (out_delta),
    .level     (level),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    q.delete();
    m_last   = '0;
    m_stop_d = 1'b0;
    m_ovf    = 1'b0;
    m_drop   = '0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".valid"},    64'(out_valid), 64'(q.size() != 0));
    chk({tag, ".level"},    64'(level),     64'(q.size()));
    chk({tag, ".overflow"}, 64'(overflow),  64'(m_ovf));
    chk({tag, ".drop_cnt"}, 64'(drop_cnt),  64'(m_drop));
  endtask

  // Drive one cycle of inputs, update the scoreboard, and advance one edge.
  task automatic apply_cycle(input logic [WIDTH-1:0] c, input logic s,
                             input logic cl, input logic r);
    logic             m_cap;
    logic             m_pop;
    logic [WIDTH-1:0] d;
    count     = c;
    stop      = s;
    clear     = cl;
    out_ready = r;
    m_cap = s && !m_stop_d;
    m_pop = (q.size() != 0) && r && !cl;
    if (m_pop) chk("pop_delta", 64'(out_delta), 64'(q[0]));
    if (cl) begin
      q.delete();
      m_ovf  = 1'b0;
      m_drop = '0;
      m_last = c;
    end else begin
      if (m_pop) void'(q.pop_front());
      if (m_cap) begin
        d      = c - m_last;
        m_last = c;
        if (q.size() < DEPTH) q.push_back(d);
        else begin
          m_ovf = 1'b1;
          if (m_drop != '1) m_drop = m_drop + 1'b1;
        end
      end
    end
    m_stop_d = s;
    step();
    check_state("cyc");
  endtask

  task automatic cap_pulse(input logic [WIDTH-1:0] c, input logic r);
    apply_cycle(c, 1'b1, 1'b0, r);
    apply_cycle(c, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Basic interval, last-popped visibility, then clear + held stop of 40.
    tbl[0]  = '{32'd90,   1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 32'd0};
    tbl[1]  = '{32'd100,  1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 32'd100};
    tbl[2]  = '{32'd100,  1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 32'd100};
    tbl[3]  = '{32'd100,  1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 32'd100};
    tbl[4]  = '{32'd250,  1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 32'd100};
    tbl[5]  = '{32'd250,  1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 1'b1, 32'd150};
    tbl[6]  = '{32'd260,  1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 32'd150};
    tbl[7]  = '{32'd260,  1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 32'd150};
    tbl[8]  = '{32'd1000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 32'd0};
    tbl[9]  = '{32'd1040, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 32'd40};
    tbl[10] = '{32'd1040, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 32'd40};
    tbl[11] = '{32'd1040, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 32'd40};
    tbl[12] = '{32'd1040, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 32'd40};
    tbl[13] = '{32'd1040, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 32'd40};
    tbl[14] = '{32'd1040, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 32'd40};
    tbl[15] = '{32'd1040, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 32'd40};

    reset_n   = 1'b0;
    count     = '0;
    stop      = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b0;
    model_reset();
    step();
    step();
    chk("rst.valid",    64'(out_valid), 64'd0);
    chk("rst.level",    64'(level),     64'd0);
    chk("rst.overflow", 64'(overflow),  64'd0);
    chk("rst.drop_cnt", 64'(drop_cnt),  64'd0);
    chk("rst.delta",    64'(out_delta), 64'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      apply_cycle(tbl[i].cnt, tbl[i].stp, tbl[i].clr, tbl[i].rdy);
      chk($sformatf("tbl%0d.valid", i), 64'(out_valid), 64'(tbl[i].exp_v));
      chk($sformatf("tbl%0d.level", i), 64'(level),     64'(tbl[i].exp_l));
      if (tbl[i].chk_d)
        chk($sformatf("tbl%0d.delta", i), 64'(out_delta), 64'(tbl[i].exp_d));
    end

    // Wrap-around: baseline just below 2^32, capture at 4 -> 10.
    apply_cycle(32'hFFFF_FFFA, 1'b0, 1'b1, 1'b0);
    apply_cycle(32'd4, 1'b1, 1'b0, 1'b0);
    chk("wrap.level", 64'(level),     64'd1);
    chk("wrap.delta", 64'(out_delta), 64'd10);
    apply_cycle(32'd4, 1'b0, 1'b0, 1'b1);

    // Overflow: six captures into a 4-deep FIFO with no consumer.
    apply_cycle(32'd0, 1'b0, 1'b1, 1'b0);
    cap_pulse(32'd10,  1'b0);
    cap_pulse(32'd30,  1'b0);
    cap_pulse(32'd60,  1'b0);
    cap_pulse(32'd100, 1'b0);
    cap_pulse(32'd150, 1'b0);
    cap_pulse(32'd210, 1'b0);
    chk("ovf.level",    64'(level),     64'd4);
    chk("ovf.overflow", 64'(overflow),  64'd1);
    chk("ovf.drop_cnt", 64'(drop_cnt),  64'd2);
    chk("ovf.head",     64'(out_delta), 64'd10);

    // Full FIFO: capture and pop in the same cycle -> no drop, level stays 4.
    cap_pulse(32'd300, 1'b1);
    chk("fullpp.level",    64'(level),    64'd4);
    chk("fullpp.drop_cnt", 64'(drop_cnt), 64'd2);
    chk("fullpp.head",     64'(out_delta), 64'd20);
    // Back-to-back drain: 20, 30, 40, then the new tail entry 90.
    for (int i = 0; i < 4; i++) apply_cycle(32'd300, 1'b0, 1'b0, 1'b1);
    chk("drain.level", 64'(level), 64'd0);
    chk("drain.last",  64'(out_delta), 64'd90);

    // Ready while empty must not move pointers.
    apply_cycle(32'd300, 1'b0, 1'b0, 1'b1);
    apply_cycle(32'd300, 1'b0, 1'b0, 1'b1);
    cap_pulse(32'd333, 1'b0);
    chk("idle_rdy.level", 64'(level),     64'd1);
    chk("idle_rdy.delta", 64'(out_delta), 64'd33);

    // Drop counter saturation: fill, then 260 further drops.
    apply_cycle(32'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 264; i++) cap_pulse(32'(i * 3), 1'b0);
    chk("sat.drop_cnt", 64'(drop_cnt), 64'd255);
    chk("sat.overflow", 64'(overflow), 64'd1);
    chk("sat.level",    64'(level),    64'd4);

    // Clear together with capture and ready at count=500.
    apply_cycle(32'd500, 1'b1, 1'b1, 1'b1);
    chk("clr.level",    64'(level),    64'd0);
    chk("clr.overflow", 64'(overflow), 64'd0);
    chk("clr.drop_cnt", 64'(drop_cnt), 64'd0);
    apply_cycle(32'd500, 1'b0, 1'b0, 1'b0);
    cap_pulse(32'd520, 1'b0);
    chk("clr.next_delta", 64'(out_delta), 64'd20);
    cap_pulse(32'd600, 1'b0);
    chk("pre_rst.level", 64'(level), 64'd2);

    // Reset mid-operation discards everything at the next edge.
    reset_n = 1'b0;
    stop    = 1'b0;
    clear   = 1'b0;
    out_ready = 1'b0;
    step();
    model_reset();
    chk("rst2.valid",    64'(out_valid), 64'd0);
    chk("rst2.level",    64'(level),     64'd0);
    chk("rst2.overflow", 64'(overflow),  64'd0);
    chk("rst2.drop_cnt", 64'(drop_cnt),  64'd0);
    chk("rst2.delta",    64'(out_delta), 64'd0);
    reset_n = 1'b1;
    apply_cycle(32'd0, 1'b0, 1'b0, 1'b0);
    cap_pulse(32'd77, 1'b0);
    chk("post_rst.delta", 64'(out_delta), 64'd77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
